// File: rtl/lcd_msg_sequencer_if.sv
// Handshake and data bundle between the SIM-reader control logic,
// the message sequencer and the LCD writer stage.
// Names carry the sequencer's point of view: i_ = into the sequencer, o_ = out of it.
interface lcd_msg_sequencer_if;
    logic         i_start;
    logic [159:0] i_linea1;
    logic [159:0] i_linea2;
    logic         i_done;
    logic         o_limpiar;
    logic         o_escribir;
    logic         o_cambioFila;
    logic [159:0] o_datoLcd;
    logic         o_busy;
    logic         o_fin;
    logic         o_error;

    // Side that supplies Start, the two text rows and the writer's Done.
    modport master (
        output i_start, i_linea1, i_linea2, i_done,
        input  o_limpiar, o_escribir, o_cambioFila, o_datoLcd, o_busy, o_fin, o_error
    );

    // The sequencer itself.
    modport slave (
        input  i_start, i_linea1, i_linea2, i_done,
        output o_limpiar, o_escribir, o_cambioFila, o_datoLcd, o_busy, o_fin, o_error
    );
endinterface

// File: rtl/lcd_msg_sequencer.sv
// LCD message sequencer: on one Start pulse it clears the panel, writes row 1,
// moves to row 2 and writes row 2, each step handshaken against the writer's Done.
// Every wait is bounded; an expired wait sets a sticky Error and returns to IDLE.
module lcd_msg_sequencer #(
    parameter int CLR_HOLD = 4,
    parameter int TIMEOUT  = 1000000,
    parameter bit CLEAR_EN = 1'b1
) (
    input logic               i_clk,
    input logic               i_rst,
    lcd_msg_sequencer_if.slave bus
);

    localparam int CNT_W = 20;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CLR_HOLD - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_CLR_WAIT,
        S_W1_REQ,
        S_W1_WAIT,
        S_ROW_REQ,
        S_ROW_WAIT,
        S_W2_REQ,
        S_W2_WAIT,
        S_FIN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [159:0]     r_l2;
    logic [159:0]     r_dato;
    logic             r_error;
    logic             w_accept;
    logic             w_expired;
    logic             w_timeout;

    // Start is only honoured from IDLE and only when the writer reports ready.
    assign w_accept  = (r_state == S_IDLE) && bus.i_start && bus.i_done;
    assign w_expired = (r_cnt == TMO_LAST);

    // Next-state logic; a handshake condition seen in the last allowed cycle wins over the timeout.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = CLEAR_EN ? S_CLR : S_W1_REQ;
                end
            end
            S_CLR: begin
                if (r_cnt == HOLD_LAST) begin
                    w_next = S_CLR_WAIT;
                end
            end
            S_CLR_WAIT: begin
                if (bus.i_done) w_next = S_W1_REQ;
                else if (w_expired) w_timeout = 1'b1;
            end
            S_W1_REQ: begin
                if (!bus.i_done) w_next = S_W1_WAIT;
                else if (w_expired) w_timeout = 1'b1;
            end
            S_W1_WAIT: begin
                if (bus.i_done) w_next = S_ROW_REQ;
                else if (w_expired) w_timeout = 1'b1;
            end
            S_ROW_REQ: begin
                if (!bus.i_done) w_next = S_ROW_WAIT;
                else if (w_expired) w_timeout = 1'b1;
            end
            S_ROW_WAIT: begin
                if (bus.i_done) w_next = S_W2_REQ;
                else if (w_expired) w_timeout = 1'b1;
            end
            S_W2_REQ: begin
                if (!bus.i_done) w_next = S_W2_WAIT;
                else if (w_expired) w_timeout = 1'b1;
            end
            S_W2_WAIT: begin
                if (bus.i_done) w_next = S_FIN;
                else if (w_expired) w_timeout = 1'b1;
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_timeout) begin
            w_next = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Shared cycle counter: restarts on every state change, serves both the clear hold and the wait bound.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if ((w_next != r_state) || (r_state == S_IDLE)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Row 2 is captured at Start so later changes on the input lines cannot leak into the sequence.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)         r_l2 <= '0;
        else if (w_accept) r_l2 <= bus.i_linea2;
    end

    // Data toward the writer: row 1 from Start onward, row 2 from the second write, held afterwards.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dato <= '0;
        end else if (w_accept) begin
            r_dato <= bus.i_linea1;
        end else if ((r_state == S_ROW_WAIT) && (w_next == S_W2_REQ)) begin
            r_dato <= r_l2;
        end
    end

    // Sticky timeout flag, cleared only by the next accepted Start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)          r_error <= 1'b0;
        else if (w_accept)  r_error <= 1'b0;
        else if (w_timeout) r_error <= 1'b1;
    end

    assign bus.o_limpiar    = (r_state == S_CLR);
    assign bus.o_escribir   = (r_state == S_W1_REQ) || (r_state == S_W2_REQ);
    assign bus.o_cambioFila = (r_state == S_ROW_REQ);
    assign bus.o_datoLcd    = r_dato;
    assign bus.o_busy       = (r_state != S_IDLE);
    assign bus.o_fin        = (r_state == S_FIN);
    assign bus.o_error      = r_error;

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Bench for lcd_msg_sequencer: two instances (with and without the clear step) share one
// writer model; a monitor logs request rises, the row data seen at each write and pulse counts.
module tb_lcd_msg_sequencer;
    localparam int TMO  = 16;
    localparam int HOLD = 4;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         startA   = 1'b0;
    logic         startB   = 1'b0;
    logic [159:0] line1    = '0;
    logic [159:0] line2    = '0;
    bit           wrDone   = 1'b1;
    bit           stuck    = 1'b0;
    bit           ideal    = 1'b1;
    bit           forceLow = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcd_msg_sequencer_if ifA();
    lcd_msg_sequencer_if ifB();

    assign ifA.i_start  = startA;
    assign ifA.i_linea1 = line1;
    assign ifA.i_linea2 = line2;
    assign ifA.i_done   = wrDone & ~forceLow;
    assign ifB.i_start  = startB;
    assign ifB.i_linea1 = line1;
    assign ifB.i_linea2 = line2;
    assign ifB.i_done   = wrDone & ~forceLow;

    lcd_msg_sequencer #(.CLR_HOLD(HOLD), .TIMEOUT(TMO), .CLEAR_EN(1'b1)) dutA (
        .i_clk(clk), .i_rst(rst), .bus(ifA.slave)
    );
    lcd_msg_sequencer #(.CLR_HOLD(HOLD), .TIMEOUT(TMO), .CLEAR_EN(1'b0)) dutB (
        .i_clk(clk), .i_rst(rst), .bus(ifB.slave)
    );

    // Only one instance runs at a time, so the writer and monitor see the OR of both.
    logic         limp, esc, cam, fin;
    logic [159:0] dato;
    assign limp = ifA.o_limpiar | ifB.o_limpiar;
    assign esc  = ifA.o_escribir | ifB.o_escribir;
    assign cam  = ifA.o_cambioFila | ifB.o_cambioFila;
    assign fin  = ifA.o_fin | ifB.o_fin;
    assign dato = ifB.o_busy ? ifB.o_datoLcd : ifA.o_datoLcd;

    int           evQ[$];
    logic [159:0] datQ[$];
    int           limpCyc  = 0;
    int           escCyc   = 0;
    int           finCnt   = 0;
    int           overlaps = 0;
    int           cycle    = 0;
    int           finAt    = -1;
    bit           pL = 1'b0, pE = 1'b0, pC = 1'b0;
    int           dly = 0, hld = 0;

    // Monitor plus writer model on the falling edge: a new request makes Done drop after
    // dly cycles and return hld cycles later (ideal writer: 1 and 2).
    always @(negedge clk) begin
        if (rst) begin
            pL = 1'b0; pE = 1'b0; pC = 1'b0;
            dly = 0; hld = 0; wrDone = 1'b1;
        end else begin
            if (limp && !pL) evQ.push_back(1);
            if (esc && !pE) begin
                evQ.push_back(2);
                datQ.push_back(dato);
            end
            if (cam && !pC) evQ.push_back(3);
            limpCyc += int'(limp);
            escCyc  += int'(esc);
            if (fin) begin
                finCnt++;
                finAt = cycle;
            end
            if (int'(limp) + int'(esc) + int'(cam) > 1) overlaps++;
            if (((limp && !pL) || (esc && !pE) || (cam && !pC)) && !stuck) begin
                dly = ideal ? 1 : int'($urandom_range(3, 1));
                hld = ideal ? 2 : int'($urandom_range(4, 1));
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) wrDone = 1'b0;
            end else if (hld > 0) begin
                hld--;
                if (hld == 0) wrDone = 1'b1;
            end
            pL = limp; pE = esc; pC = cam;
        end
        cycle++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // One full sequence on instance A or B, optionally with a stray Start and mid-run line changes.
    task automatic applyStimulus(input bit useB, input bit extraStart, input bit changeLines,
                                 input logic [159:0] l1, input logic [159:0] l2);
        int  e0, d0, lc0, f0, o0, sc, k, lat;
        bit  ended;
        int  expEv[$];
        line1 = l1;
        line2 = l2;
        e0 = evQ.size(); d0 = datQ.size(); lc0 = limpCyc; f0 = finCnt; o0 = overlaps;
        tick;
        if (useB) startB = 1'b1; else startA = 1'b1;
        sc = cycle;
        tick;
        startA = 1'b0; startB = 1'b0;
        checkOutput("busyAfterStart", 160'(useB ? ifB.o_busy : ifA.o_busy), 160'(1));
        checkOutput("errorClearedByStart", 160'(useB ? ifB.o_error : ifA.o_error), 160'(0));
        k = 1;
        ended = 1'b0;
        while (!ended && k < 300) begin
            tick;
            k++;
            if (k == 3 && changeLines) begin
                line1 = ~l1;
                line2 = ~l2;
            end
            if (k == 5 && extraStart) begin
                if (useB) startB = 1'b1; else startA = 1'b1;
            end
            if (k == 6) begin
                startA = 1'b0; startB = 1'b0;
            end
            if (!(useB ? ifB.o_busy : ifA.o_busy)) ended = 1'b1;
        end
        checkCount("sequenceEnds", int'(ended), 1);
        if (!useB) expEv.push_back(1);
        expEv.push_back(2); expEv.push_back(3); expEv.push_back(2);
        checkCount("requestCount", evQ.size() - e0, expEv.size());
        for (int i = 0; i < expEv.size(); i++) begin
            if (e0 + i < evQ.size()) checkCount("requestOrder", evQ[e0 + i], expEv[i]);
        end
        checkCount("writeCount", datQ.size() - d0, 2);
        if (datQ.size() >= d0 + 2) begin
            checkOutput("datoAtWrite1", datQ[d0], l1);
            checkOutput("datoAtWrite2", datQ[d0 + 1], l2);
        end
        checkCount("limpiarCycles", limpCyc - lc0, useB ? 0 : HOLD);
        checkCount("finPulses", finCnt - f0, 1);
        checkCount("requestOverlap", overlaps - o0, 0);
        checkOutput("errorAfterRun", 160'(useB ? ifB.o_error : ifA.o_error), 160'(0));
        checkOutput("datoHoldsRow2", useB ? ifB.o_datoLcd : ifA.o_datoLcd, l2);
        if (ideal) begin
            lat = finAt - sc + 1;
            checkCount("latencyInWindow",
                       int'(useB ? (lat >= 13 && lat <= 15) : (lat >= 18 && lat <= 20)), 1);
        end
    endtask

    function automatic logic [159:0] randLine();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int           e0, ec0, f0, k;
        bit           seen, ended;
        logic [159:0] title;
        title = "SIM READER      ICCD";

        $display("[TB] reset state");
        rst = 1'b1;
        repeat (3) tick;
        checkOutput("rstLimpiar",  160'(ifA.o_limpiar), 160'(0));
        checkOutput("rstEscribir", 160'(ifA.o_escribir), 160'(0));
        checkOutput("rstCambio",   160'(ifA.o_cambioFila), 160'(0));
        checkOutput("rstBusy",     160'(ifA.o_busy), 160'(0));
        checkOutput("rstFin",      160'(ifA.o_fin), 160'(0));
        checkOutput("rstError",    160'(ifA.o_error), 160'(0));
        checkOutput("rstDato",     ifA.o_datoLcd, 160'(0));
        checkOutput("rstBusyB",    160'(ifB.o_busy), 160'(0));
        rst = 1'b0;
        tick;

        $display("[TB] ideal writer, title row");
        ideal = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, title, randLine());

        $display("[TB] stray Start mid-sequence");
        applyStimulus(1'b0, 1'b1, 1'b0, randLine(), randLine());

        $display("[TB] input lines change mid-sequence");
        applyStimulus(1'b0, 1'b0, 1'b1, randLine(), randLine());

        $display("[TB] random writer timing");
        ideal = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), randLine(), randLine());
        end

        $display("[TB] no clear step");
        ideal = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, randLine(), randLine());
        ideal = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, randLine(), randLine());
        ideal = 1'b1;

        $display("[TB] Start while writer not ready");
        forceLow = 1'b1;
        tick;
        startA = 1'b1;
        tick;
        startA = 1'b0;
        repeat (3) tick;
        checkOutput("startIgnoredDoneLow", 160'(ifA.o_busy), 160'(0));
        forceLow = 1'b0;
        tick;

        $display("[TB] writer stuck during first write");
        stuck = 1'b1;
        e0 = evQ.size(); ec0 = escCyc; f0 = finCnt;
        line1 = randLine();
        startA = 1'b1;
        tick;
        startA = 1'b0;
        k = 0;
        ended = 1'b0;
        while (!ended && k < 100) begin
            tick;
            k++;
            if (!ifA.o_busy) ended = 1'b1;
        end
        checkCount("timeoutEnds", int'(ended), 1);
        checkOutput("timeoutError",    160'(ifA.o_error), 160'(1));
        checkOutput("timeoutEscribir", 160'(ifA.o_escribir), 160'(0));
        checkOutput("timeoutBusy",     160'(ifA.o_busy), 160'(0));
        checkCount("timeoutNoFin", finCnt - f0, 0);
        checkCount("timeoutEscCycles", escCyc - ec0, TMO);
        checkCount("timeoutRequests", evQ.size() - e0, 2);
        stuck = 1'b0;
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, randLine(), randLine());

        $display("[TB] reset during row-change wait");
        line1 = randLine();
        startA = 1'b1;
        tick;
        startA = 1'b0;
        seen = 1'b0;
        ended = 1'b0;
        k = 0;
        while (!ended && k < 100) begin
            tick;
            k++;
            if (ifA.o_cambioFila) seen = 1'b1;
            else if (seen) ended = 1'b1;
        end
        checkCount("reachedRowWait", int'(ended), 1);
        rst = 1'b1;
        #1;
        checkOutput("midRstBusy",     160'(ifA.o_busy), 160'(0));
        checkOutput("midRstEscribir", 160'(ifA.o_escribir), 160'(0));
        checkOutput("midRstCambio",   160'(ifA.o_cambioFila), 160'(0));
        checkOutput("midRstLimpiar",  160'(ifA.o_limpiar), 160'(0));
        checkOutput("midRstDato",     ifA.o_datoLcd, 160'(0));
        repeat (2) tick;
        rst = 1'b0;
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, randLine(), randLine());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
